snoop_ac_queue: RTL and testbench

AC-channel request buffer between the ACE interconnect snoop port and the data-cache snoop controller. It absorbs bursts of snoop requests in an in-order FIFO. It also tracks how many forwarded snoops are still waiting for their CR response, so the interconnect is never blocked on AC while the controller is busy. Forwarding stops while the outstanding limit is reached.

---
 rtl/snoop_ac_queue.sv | 181 ++++++++++++++++++
 tb/tb_snoop_ac_queue.sv | 519 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_ac_queue.sv
// -----------------------------------------------------------------------------
// snoop_ac_queue
//
// In-order buffer for ACE AC-channel snoop requests. It sits between the
// interconnect snoop port and the data-cache snoop controller. Requests are
// absorbed into a small FIFO so the interconnect is not stalled on AC while
// the controller is busy. The queue also tracks snoops that were handed to
// the controller but have not yet seen their CR handshake. Forwarding pauses
// while that count sits at MaxOutstanding.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   ac_valid_i     upstream AC request valid
//   ac_ready_o     upstream AC ready (FIFO not full, not in reset)
//   ac_addr_i      upstream snoop address
//   ac_snoop_i     upstream snoop type
//   ac_prot_i      upstream prot
//   ac_valid_o     downstream AC valid (FIFO not empty, outstanding limit free)
//   ac_ready_i     downstream AC ready
//   ac_addr_o      head-entry address
//   ac_snoop_o     head-entry snoop type
//   ac_prot_o      head-entry prot
//   cr_done_i      one-cycle pulse per completed downstream CR handshake
//   count_o        current FIFO occupancy
//   outstanding_o  forwarded snoops still waiting for CR
//   err_o          sticky flag: CR completion with nothing outstanding
// -----------------------------------------------------------------------------
module snoop_ac_queue #(
  parameter int Depth          = 4,
  parameter int MaxOutstanding = 1,
  parameter int AddrWidth      = 64,
  parameter int SnoopWidth     = 4,
  parameter int ProtWidth      = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         ac_valid_i,
  output logic                         ac_ready_o,
  input  logic [AddrWidth-1:0]         ac_addr_i,
  input  logic [SnoopWidth-1:0]        ac_snoop_i,
  input  logic [ProtWidth-1:0]         ac_prot_i,
  output logic                         ac_valid_o,
  input  logic                         ac_ready_i,
  output logic [AddrWidth-1:0]         ac_addr_o,
  output logic [SnoopWidth-1:0]        ac_snoop_o,
  output logic [ProtWidth-1:0]         ac_prot_o,
  input  logic                         cr_done_i,
  output logic [$clog2(Depth+1)-1:0]   count_o,
  output logic [2:0]                   outstanding_o,
  output logic                         err_o
);

  localparam int PtrW   = $clog2(Depth);
  localparam int CntW   = $clog2(Depth + 1);
  localparam int EntryW = AddrWidth + SnoopWidth + ProtWidth;

  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
  localparam logic [2:0]      MaxOut   = 3'(MaxOutstanding);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PtrW-1:0] wptr_reg, wptr_next;
  logic [PtrW-1:0] rptr_reg, rptr_next;
  logic [CntW-1:0] count_reg, count_next;
  logic [2:0]      outstanding_reg, outstanding_next;
  logic            err_reg, err_next;

  logic              push;
  logic              pop;
  logic [EntryW-1:0] wr_entry;
  logic [EntryW-1:0] rd_entry;
  logic [EntryW-1:0] rd_entries [Depth];

  // ---------------------------------------------------------------------------
  // Handshakes
  // Both flags come from registered state only, so there is no combinational
  // path between the upstream and downstream sides. This is why a full queue
  // refuses a push even when a pop happens in the same cycle.
  // ---------------------------------------------------------------------------
  assign ac_ready_o = (count_reg != DepthCnt) & ~rst_i;
  assign ac_valid_o = (count_reg != '0) & (outstanding_reg < MaxOut);

  assign push = ac_valid_i & ac_ready_o;
  assign pop  = ac_valid_o & ac_ready_i;

  assign wr_entry = {ac_addr_i, ac_snoop_i, ac_prot_i};

  // ---------------------------------------------------------------------------
  // Entry storage
  // One register per slot. Only the slot under wptr loads on a push. Storage
  // is not reset; ac_valid_o masks stale contents.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < Depth; gi++) begin : g_entry
      logic [EntryW-1:0] entry_reg;

      always_ff @(posedge clk_i) begin
        if (push && (wptr_reg == PtrW'(gi))) begin
          entry_reg <= wr_entry;
        end
      end

      assign rd_entries[gi] = entry_reg;
    end
  endgenerate

  // The head is read straight from the slot under rptr. The slot cannot be
  // overwritten while it is the head, because a full queue blocks pushes.
  // The payload therefore holds steady during a downstream stall.
  assign rd_entry = rd_entries[rptr_reg];

  assign ac_addr_o  = rd_entry[EntryW-1 -: AddrWidth];
  assign ac_snoop_o = rd_entry[ProtWidth +: SnoopWidth];
  assign ac_prot_o  = rd_entry[ProtWidth-1:0];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    wptr_next        = wptr_reg;
    rptr_next        = rptr_reg;
    count_next       = count_reg;
    outstanding_next = outstanding_reg;
    err_next         = err_reg;

    // Depth is a power of two, so natural pointer overflow is the wrap.
    if (push) begin
      wptr_next = wptr_reg + PtrW'(1);
    end
    if (pop) begin
      rptr_next = rptr_reg + PtrW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_next = count_reg + CntW'(1);
      2'b01:   count_next = count_reg - CntW'(1);
      default: count_next = count_reg;
    endcase

    // A pop and a CR completion in the same cycle cancel out. A lone CR
    // completion with nothing outstanding has no matching snoop. In that
    // case the counter stays at zero instead of underflowing, and the error
    // is latched.
    if (pop && !cr_done_i) begin
      outstanding_next = outstanding_reg + 3'd1;
    end else if (cr_done_i && !pop) begin
      if (outstanding_reg == 3'd0) begin
        err_next = 1'b1;
      end else begin
        outstanding_next = outstanding_reg - 3'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_reg        <= '0;
      rptr_reg        <= '0;
      count_reg       <= '0;
      outstanding_reg <= '0;
      err_reg         <= 1'b0;
    end else begin
      wptr_reg        <= wptr_next;
      rptr_reg        <= rptr_next;
      count_reg       <= count_next;
      outstanding_reg <= outstanding_next;
      err_reg         <= err_next;
    end
  end

  assign count_o       = count_reg;
  assign outstanding_o = outstanding_reg;
  assign err_o         = err_reg;

endmodule

// File: tb/tb_snoop_ac_queue.sv
// -----------------------------------------------------------------------------
// tb_snoop_ac_queue
//
// Test bench for snoop_ac_queue. It drives two instances from shared inputs:
//   dut1: Depth=4, MaxOutstanding=1
//   dut2: Depth=4, MaxOutstanding=2
//
// A negedge monitor keeps a scoreboard for dut1:
//   - accepted pushes are queued;
//   - each pop is compared with the queue head;
//   - occupancy, outstanding, valid/ready and stall stability are checked
//     every cycle.
// Directed tasks add inline checks on specific cycles.
// -----------------------------------------------------------------------------
module tb_snoop_ac_queue;

  localparam int Depth = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic [63:0] in_addr;
  logic [3:0]  in_snoop;
  logic [2:0]  in_prot;
  logic        out_ready;
  logic        cr_done;

  logic        rdy1, vld1, err1;
  logic [63:0] addr1;
  logic [3:0]  snoop1;
  logic [2:0]  prot1;
  logic [2:0]  cnt1;
  logic [2:0]  out1;

  logic        rdy2, vld2, err2;
  logic [63:0] addr2;
  logic [3:0]  snoop2;
  logic [2:0]  prot2;
  logic [2:0]  cnt2;
  logic [2:0]  out2;

  snoop_ac_queue #(.Depth(Depth), .MaxOutstanding(1)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .ac_valid_i(in_valid), .ac_ready_o(rdy1),
    .ac_addr_i(in_addr), .ac_snoop_i(in_snoop), .ac_prot_i(in_prot),
    .ac_valid_o(vld1), .ac_ready_i(out_ready),
    .ac_addr_o(addr1), .ac_snoop_o(snoop1), .ac_prot_o(prot1),
    .cr_done_i(cr_done), .count_o(cnt1), .outstanding_o(out1), .err_o(err1)
  );

  snoop_ac_queue #(.Depth(Depth), .MaxOutstanding(2)) dut2 (
    .clk_i(clk), .rst_i(rst),
    .ac_valid_i(in_valid), .ac_ready_o(rdy2),
    .ac_addr_i(in_addr), .ac_snoop_i(in_snoop), .ac_prot_i(in_prot),
    .ac_valid_o(vld2), .ac_ready_i(out_ready),
    .ac_addr_o(addr2), .ac_snoop_o(snoop2), .ac_prot_o(prot2),
    .cr_done_i(cr_done), .count_o(cnt2), .outstanding_o(out2), .err_o(err2)
  );

  int errors = 0;
  int checks = 0;

  // Scoreboard state for dut1
  logic [70:0] exp_q [$];
  logic [70:0] exp_entry;
  logic [70:0] prev_payload;
  logic        stall_prev;
  int          model_out;
  logic [2:0]  exp_cnt;
  logic        exp_vld;
  logic        exp_rdy;
  logic        mon_push;
  logic        mon_pop;

  // ---------------------------------------------------------------------------
  // Monitor
  // Runs on the negedge: inputs set after the previous posedge are stable, and
  // outputs have settled. The handshakes seen here are exactly the ones the
  // next posedge will act on.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_out  = 0;
      stall_prev = 1'b0;
    end else begin
      exp_cnt = 3'(exp_q.size());
      exp_vld = (exp_q.size() != 0) && (model_out < 1);
      exp_rdy = (exp_q.size() != Depth);

      checks++;
      if (cnt1 !== exp_cnt) begin
        errors++;
        $display("FAIL mon_count: got %0d expected %0d", cnt1, exp_cnt);
      end

      checks++;
      if (!(cnt1 <= 3'(Depth))) begin
        errors++;
        $display("FAIL mon_count_bound: got %0d expected <= %0d", cnt1, Depth);
      end

      checks++;
      if (out1 !== 3'(model_out)) begin
        errors++;
        $display("FAIL mon_outstanding: got %0d expected %0d", out1, model_out);
      end

      checks++;
      if (!(out1 <= 3'd1)) begin
        errors++;
        $display("FAIL mon_outstanding_bound: got %0d expected <= 1", out1);
      end

      checks++;
      if (vld1 !== exp_vld) begin
        errors++;
        $display("FAIL mon_valid: got %0b expected %0b", vld1, exp_vld);
      end

      checks++;
      if (rdy1 !== exp_rdy) begin
        errors++;
        $display("FAIL mon_ready: got %0b expected %0b", rdy1, exp_rdy);
      end

      if (stall_prev) begin
        checks++;
        if ({vld1, addr1, snoop1, prot1} !== {1'b1, prev_payload}) begin
          errors++;
          $display("FAIL mon_stall_stable: got v=%0b %h expected v=1 %h",
                   vld1, {addr1, snoop1, prot1}, prev_payload);
        end
      end

      mon_pop  = vld1 && out_ready;
      mon_push = in_valid && rdy1;

      if (mon_pop) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL mon_pop_empty: got pop addr=%h expected no pop", addr1);
        end else begin
          exp_entry = exp_q.pop_front();
          if ({addr1, snoop1, prot1} !== exp_entry) begin
            errors++;
            $display("FAIL mon_order: got %h expected %h",
                     {addr1, snoop1, prot1}, exp_entry);
          end else begin
            $display("pop addr=%h snoop=%h prot=%h", addr1, snoop1, prot1);
          end
        end
      end

      if (mon_push) begin
        exp_q.push_back({in_addr, in_snoop, in_prot});
      end

      if (mon_pop && !cr_done) begin
        model_out++;
      end else if (cr_done && !mon_pop && model_out > 0) begin
        model_out--;
      end

      stall_prev   = vld1 && !out_ready;
      prev_payload = {addr1, snoop1, prot1};
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic v, input logic [63:0] a);
    in_valid = v;
    in_addr  = a;
    in_snoop = a[7:4];
    in_prot  = a[10:8];
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cr_done   = 1'b0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cr_done   = 1'b0;
    set_push(1'b0, 64'h0);
    repeat (2) tick();

    checks++;
    if (rdy1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_in_rst: got %0b expected 0", rdy1);
    end

    checks++;
    if (rdy2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready2_in_rst: got %0b expected 0", rdy2);
    end

    rst = 1'b0;
    #1;

    checks++;
    if (rdy1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %0b expected 1", rdy1);
    end

    checks++;
    if ({vld1, cnt1, out1, err1} !== {1'b0, 3'd0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state1: got v=%0b c=%0d o=%0d e=%0b expected 0/0/0/0",
               vld1, cnt1, out1, err1);
    end

    checks++;
    if ({vld2, cnt2, out2, err2} !== {1'b0, 3'd0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state2: got v=%0b c=%0d o=%0d e=%0b expected 0/0/0/0",
               vld2, cnt2, out2, err2);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    out_ready = 1'b1;
    set_push(1'b1, 64'h80);
    tick();

    // 0x80 visible one cycle after its push
    checks++;
    if ({vld1, addr1} !== {1'b1, 64'h80}) begin
      errors++;
      $display("FAIL basic_first: got v=%0b a=%h expected v=1 a=80", vld1, addr1);
    end

    set_push(1'b1, 64'h90);
    tick();

    checks++;
    if ({vld1, out1} !== {1'b0, 3'd1}) begin
      errors++;
      $display("FAIL basic_block: got v=%0b o=%0d expected v=0 o=1", vld1, out1);
    end

    set_push(1'b1, 64'hA0);
    tick();
    set_push(1'b0, 64'h0);

    checks++;
    if ({vld1, cnt1} !== {1'b0, 3'd2}) begin
      errors++;
      $display("FAIL basic_held: got v=%0b c=%0d expected v=0 c=2", vld1, cnt1);
    end

    cr_done = 1'b1;
    tick();
    cr_done = 1'b0;

    checks++;
    if ({vld1, addr1, out1} !== {1'b1, 64'h90, 3'd0}) begin
      errors++;
      $display("FAIL basic_second: got v=%0b a=%h o=%0d expected v=1 a=90 o=0",
               vld1, addr1, out1);
    end

    tick();

    checks++;
    if (vld1 !== 1'b0) begin
      errors++;
      $display("FAIL basic_block2: got v=%0b expected 0", vld1);
    end

    cr_done = 1'b1;
    tick();
    cr_done = 1'b0;

    checks++;
    if ({vld1, addr1} !== {1'b1, 64'hA0}) begin
      errors++;
      $display("FAIL basic_third: got v=%0b a=%h expected v=1 a=a0", vld1, addr1);
    end

    tick();
    cr_done = 1'b1;
    tick();
    cr_done = 1'b0;

    checks++;
    if ({vld1, cnt1, out1, err1} !== {1'b0, 3'd0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL basic_end: got v=%0b c=%0d o=%0d e=%0b expected 0/0/0/0",
               vld1, cnt1, out1, err1);
    end
  endtask

  task automatic test_full_wrap();
    apply_reset();
    out_ready = 1'b0;

    for (int i = 0; i < 5; i++) begin
      set_push(1'b1, 64'h100 + 64'(i * 16));
      #1;
      checks++;
      if (rdy1 !== (i < 4)) begin
        errors++;
        $display("FAIL full_ready_%0d: got %0b expected %0b", i, rdy1, (i < 4));
      end
      tick();
    end
    set_push(1'b0, 64'h0);

    checks++;
    if ({cnt1, rdy1} !== {3'd4, 1'b0}) begin
      errors++;
      $display("FAIL full_count: got c=%0d r=%0b expected c=4 r=0", cnt1, rdy1);
    end

    // Drain with a CR completion alongside every pop: outstanding stays 0.
    out_ready = 1'b1;
    for (int k = 0; k < 12 && cnt1 != 3'd0; k++) begin
      cr_done = vld1;
      tick();
    end
    cr_done = 1'b0;

    checks++;
    if ({cnt1, out1, err1} !== {3'd0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL full_drain: got c=%0d o=%0d e=%0b expected 0/0/0",
               cnt1, out1, err1);
    end
  endtask

  task automatic test_max2();
    apply_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_push(1'b1, 64'h200 + 64'(i * 16));
      tick();
    end
    set_push(1'b0, 64'h0);

    out_ready = 1'b1;
    tick();

    checks++;
    if ({out2, vld2} !== {3'd1, 1'b1}) begin
      errors++;
      $display("FAIL max2_one: got o=%0d v=%0b expected o=1 v=1", out2, vld2);
    end

    cr_done = 1'b1;  // pop and completion together
    tick();
    cr_done = 1'b0;

    checks++;
    if ({out2, vld2, cnt2} !== {3'd1, 1'b1, 3'd2}) begin
      errors++;
      $display("FAIL max2_cancel: got o=%0d v=%0b c=%0d expected o=1 v=1 c=2",
               out2, vld2, cnt2);
    end

    tick();

    checks++;
    if ({out2, vld2} !== {3'd2, 1'b0}) begin
      errors++;
      $display("FAIL max2_limit: got o=%0d v=%0b expected o=2 v=0", out2, vld2);
    end

    tick();

    checks++;
    if ({out2, vld2, cnt2} !== {3'd2, 1'b0, 3'd1}) begin
      errors++;
      $display("FAIL max2_hold: got o=%0d v=%0b c=%0d expected o=2 v=0 c=1",
               out2, vld2, cnt2);
    end

    cr_done = 1'b1;
    tick();
    cr_done = 1'b0;

    checks++;
    if ({out2, vld2, addr2} !== {3'd1, 1'b1, 64'h230}) begin
      errors++;
      $display("FAIL max2_release: got o=%0d v=%0b a=%h expected o=1 v=1 a=230",
               out2, vld2, addr2);
    end

    tick();
    cr_done = 1'b1;
    repeat (2) tick();
    cr_done = 1'b0;

    checks++;
    if ({out2, cnt2, err2} !== {3'd0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL max2_end: got o=%0d c=%0d e=%0b expected 0/0/0",
               out2, cnt2, err2);
    end
  endtask

  task automatic test_error();
    apply_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_push(1'b1, 64'h300 + 64'(i * 16));
      tick();
    end
    set_push(1'b0, 64'h0);

    cr_done = 1'b1;
    tick();
    cr_done = 1'b0;

    checks++;
    if ({err1, out1, cnt1} !== {1'b1, 3'd0, 3'd2}) begin
      errors++;
      $display("FAIL err_set: got e=%0b o=%0d c=%0d expected e=1 o=0 c=2",
               err1, out1, cnt1);
    end

    repeat (2) tick();

    checks++;
    if ({err1, err2, out1} !== {1'b1, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL err_sticky: got e1=%0b e2=%0b o=%0d expected 1/1/0",
               err1, err2, out1);
    end

    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;

    checks++;
    if ({err1, cnt1, rdy1, vld1} !== {1'b0, 3'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL err_clear: got e=%0b c=%0d r=%0b v=%0b expected 0/0/1/0",
               err1, cnt1, rdy1, vld1);
    end
  endtask

  task automatic test_random();
    apply_reset();

    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_addr   = {$urandom, $urandom};
      in_snoop  = 4'($urandom);
      in_prot   = 3'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      cr_done   = (model_out > 0) && ($urandom_range(0, 2) == 0);
      tick();
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 40 && (exp_q.size() != 0 || model_out != 0); k++) begin
      cr_done = (model_out > 0);
      tick();
    end
    cr_done = 1'b0;
    tick();

    checks++;
    if ({cnt1, out1, err1} !== {3'd0, 3'd0, 1'b0} || exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_drain: got c=%0d o=%0d e=%0b q=%0d expected 0/0/0/0",
               cnt1, out1, err1, exp_q.size());
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_addr   = '0;
    in_snoop  = '0;
    in_prot   = '0;
    out_ready = 1'b0;
    cr_done   = 1'b0;

    test_reset();
    test_basic();
    test_full_wrap();
    test_max2();
    test_error();
    test_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
